// File: rtl/mem_op_pkg.sv
// Shared types and helpers for the load/store op decoder and its output FIFO.
package mem_op_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic      store;
    mem_size_e size;
    logic      signed_en;
  } mem_op_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Byte-lane pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_lanes(input mem_size_e s);
    case (s)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input mem_size_e s);
    case (s)
      MEM_B:   return 3'b000;
      MEM_H:   return 3'b001;
      MEM_W:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_op_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; pointer pair plus occupancy count.
module mem_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_op_decode_q.sv
// Load/store op decoder: decodes size/sign, computes address, byte enables and
// fault flags, and queues results toward the memory stage.
module mem_op_decode_q
  import mem_op_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_base,
  input  logic [11:0]       in_imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output mem_op_t           out_op,
  output logic [XLEN-1:0]   out_addr,
  output logic [XLEN/8-1:0] out_be,
  output logic              out_misaligned,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       misaligned_cnt
);

  localparam int  BE_W    = XLEN / 8;
  localparam int  OFF_W   = $clog2(BE_W);
  localparam bit  IS_RV32 = (XLEN == 32);

  typedef struct packed {
    mem_op_t           op;
    logic [XLEN-1:0]   addr;
    logic [BE_W-1:0]   be;
    logic              misaligned;
    logic              illegal;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t      entry_d, head, head_vis;
  mem_size_e   sz;
  logic [BE_W-1:0] lanes;
  logic        push, pop, fifo_full;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sz                = mem_size_e'(in_funct3[1:0]);
    entry_d           = '0;
    entry_d.op        = '{store: in_op[5], size: sz, signed_en: !in_funct3[2]};
    entry_d.addr      = in_base + {{(XLEN-12){in_imm[11]}}, in_imm};
    entry_d.tag       = in_tag;
    entry_d.illegal   = ((in_op != OP_LOAD) && (in_op != OP_STORE))
                        || (sz == MEM_D && IS_RV32)
                        || (in_op[5] && in_funct3[2])
                        || (in_funct3 == 3'b111);
    entry_d.misaligned = !entry_d.illegal && (|(entry_d.addr[2:0] & size_mask(sz)));
    lanes             = BE_W'(size_lanes(sz));
    entry_d.be        = (entry_d.illegal || entry_d.misaligned) ? '0
                        : (lanes << entry_d.addr[OFF_W-1:0]);
  end

  // Acceptance depends only on rst/flush/occupancy, never on out_ready.
  assign in_ready = !rst && !flush && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  mem_op_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (entry_d),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (out_valid),
    .full_o  (fifo_full)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (push && entry_d.misaligned && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign head_vis       = out_valid ? head : '0;
  assign out_op         = head_vis.op;
  assign out_addr       = head_vis.addr;
  assign out_be         = head_vis.be;
  assign out_misaligned = head_vis.misaligned;
  assign out_illegal    = head_vis.illegal;
  assign out_tag        = head_vis.tag;
  assign misaligned_cnt = cnt_q;

endmodule

// File: tb/tb_mem_op_decode_q.sv
// Directed bench for mem_op_decode_q: one RV32 and one RV64 instance.
module tb_mem_op_decode_q;
  import mem_op_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        flush_a, iv_a, ir_a, ov_a, or_a, mis_a, ill_a;
  logic [6:0]  op_a;
  logic [2:0]  f3_a;
  logic [31:0] base_a, addr_a;
  logic [11:0] imm_a;
  logic [3:0]  tag_a, otag_a, be_a;
  mem_op_t     oop_a;
  logic [15:0] cnt_a;

  logic        flush_b, iv_b, ir_b, ov_b, or_b, mis_b, ill_b;
  logic [6:0]  op_b;
  logic [2:0]  f3_b;
  logic [63:0] base_b, addr_b;
  logic [11:0] imm_b;
  logic [3:0]  tag_b, otag_b;
  logic [7:0]  be_b;
  mem_op_t     oop_b;
  logic [15:0] cnt_b;

  int vecs = 0;
  int errs = 0;

  mem_op_decode_q #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_op(op_a), .in_funct3(f3_a), .in_base(base_a), .in_imm(imm_a), .in_tag(tag_a),
    .out_valid(ov_a), .out_ready(or_a), .out_op(oop_a), .out_addr(addr_a), .out_be(be_a),
    .out_misaligned(mis_a), .out_illegal(ill_a), .out_tag(otag_a), .misaligned_cnt(cnt_a)
  );

  mem_op_decode_q #(.XLEN(64), .DEPTH(2), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_op(op_b), .in_funct3(f3_b), .in_base(base_b), .in_imm(imm_b), .in_tag(tag_b),
    .out_valid(ov_b), .out_ready(or_b), .out_op(oop_b), .out_addr(addr_b), .out_be(be_b),
    .out_misaligned(mis_b), .out_illegal(ill_b), .out_tag(otag_b), .misaligned_cnt(cnt_b)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] imm, input logic [3:0] tag);
    op_a = op; f3_a = f3; base_a = base; imm_a = imm; tag_a = tag;
  endtask

  task automatic drive_b(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] base,
                         input logic [11:0] imm, input logic [3:0] tag);
    op_b = op; f3_b = f3; base_b = base; imm_b = imm; tag_b = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_a = 0; iv_a = 0; or_a = 0; flush_b = 0; iv_b = 0; or_b = 0;
    drive_a(7'd0, 3'd0, 32'd0, 12'd0, 4'd0);
    drive_b(7'd0, 3'd0, 64'd0, 12'd0, 4'd0);
    repeat (2) cyc();
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL reset_ov32: got %b want 0", ov_a); end
    vecs++; if (ir_a !== 1'b0) begin errs++; $display("FAIL reset_ir32: got %b want 0", ir_a); end
    vecs++; if (cnt_a !== 16'd0) begin errs++; $display("FAIL reset_cnt: got %h want 0", cnt_a); end
    vecs++; if (addr_a !== 32'd0) begin errs++; $display("FAIL reset_addr: got %h want 0", addr_a); end
    vecs++; if (ov_b !== 1'b0) begin errs++; $display("FAIL reset_ov64: got %b want 0", ov_b); end
    rst = 1'b0;
    #1;
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL post_reset_ir: got %b want 1", ir_a); end
    cyc();
  endtask

  task automatic test_lw();
    drive_a(OP_LOAD, 3'b010, 32'h1000, 12'h004, 4'd1);
    iv_a = 1'b1;
    #1;
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL lw_pre_ov: got %b want 0", ov_a); end
    cyc();
    iv_a = 1'b0;
    vecs++; if (ov_a !== 1'b1) begin errs++; $display("FAIL lw_latency: got %b want 1", ov_a); end
    vecs++; if (addr_a !== 32'h1004) begin errs++; $display("FAIL lw_addr: got %h want 1004", addr_a); end
    vecs++; if (be_a !== 4'b1111) begin errs++; $display("FAIL lw_be: got %b want 1111", be_a); end
    vecs++; if ({mis_a, ill_a} !== 2'b00) begin errs++; $display("FAIL lw_flags: got %b want 00", {mis_a, ill_a}); end
    vecs++; if (oop_a !== 4'b0101) begin errs++; $display("FAIL lw_op: got %b want 0101", oop_a); end
    vecs++; if (otag_a !== 4'd1) begin errs++; $display("FAIL lw_tag: got %0d want 1", otag_a); end
    or_a = 1'b1; cyc(); or_a = 1'b0;
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL lw_pop: got %b want 0", ov_a); end
  endtask

  task automatic test_wrap();
    drive_a(OP_LOAD, 3'b000, 32'hFFFF_FFFF, 12'h001, 4'd2);
    iv_a = 1'b1; cyc(); iv_a = 1'b0;
    vecs++; if (addr_a !== 32'h0) begin errs++; $display("FAIL wrap_addr: got %h want 0", addr_a); end
    vecs++; if (be_a !== 4'b0001) begin errs++; $display("FAIL wrap_be: got %b want 0001", be_a); end
    vecs++; if ({mis_a, ill_a} !== 2'b00) begin errs++; $display("FAIL wrap_flags: got %b want 00", {mis_a, ill_a}); end
    or_a = 1'b1; cyc(); or_a = 1'b0;
  endtask

  task automatic test_ld32();
    drive_a(OP_LOAD, 3'b011, 32'h2000, 12'h000, 4'd3);
    iv_a = 1'b1; cyc(); iv_a = 1'b0;
    vecs++; if (ill_a !== 1'b1) begin errs++; $display("FAIL ld32_illegal: got %b want 1", ill_a); end
    vecs++; if (be_a !== 4'b0000) begin errs++; $display("FAIL ld32_be: got %b want 0000", be_a); end
    vecs++; if (mis_a !== 1'b0) begin errs++; $display("FAIL ld32_mis: got %b want 0", mis_a); end
    or_a = 1'b1; cyc(); or_a = 1'b0;
  endtask

  task automatic test_rv64();
    drive_b(OP_STORE, 3'b011, 64'h10, 12'hFF8, 4'd4);
    iv_b = 1'b1; cyc(); iv_b = 1'b0;
    vecs++; if (addr_b !== 64'h8) begin errs++; $display("FAIL sd_addr: got %h want 8", addr_b); end
    vecs++; if (be_b !== 8'hFF) begin errs++; $display("FAIL sd_be: got %h want ff", be_b); end
    vecs++; if (oop_b !== 4'b1111) begin errs++; $display("FAIL sd_op: got %b want 1111", oop_b); end
    vecs++; if ({mis_b, ill_b} !== 2'b00) begin errs++; $display("FAIL sd_flags: got %b want 00", {mis_b, ill_b}); end
    vecs++; if (otag_b !== 4'd4) begin errs++; $display("FAIL sd_tag: got %0d want 4", otag_b); end
    or_b = 1'b1; cyc(); or_b = 1'b0;

    drive_b(OP_STORE, 3'b100, 64'h20, 12'h000, 4'd5);
    iv_b = 1'b1; cyc(); iv_b = 1'b0;
    vecs++; if (ill_b !== 1'b1) begin errs++; $display("FAIL sbu_illegal: got %b want 1", ill_b); end
    vecs++; if (be_b !== 8'h00) begin errs++; $display("FAIL sbu_be: got %h want 00", be_b); end
    or_b = 1'b1; cyc(); or_b = 1'b0;

    drive_b(OP_LOAD, 3'b010, 64'h4, 12'h000, 4'd6);
    iv_b = 1'b1; cyc(); iv_b = 1'b0;
    vecs++; if (be_b !== 8'hF0) begin errs++; $display("FAIL lw64_be: got %h want f0", be_b); end
    vecs++; if (addr_b !== 64'h4) begin errs++; $display("FAIL lw64_addr: got %h want 4", addr_b); end
    or_b = 1'b1; cyc(); or_b = 1'b0;

    drive_b(7'b0010011, 3'b000, 64'h0, 12'h000, 4'd7);
    iv_b = 1'b1; cyc(); iv_b = 1'b0;
    vecs++; if (ill_b !== 1'b1) begin errs++; $display("FAIL badop_illegal: got %b want 1", ill_b); end
    or_b = 1'b1; cyc(); or_b = 1'b0;

    drive_b(OP_LOAD, 3'b011, 64'h12, 12'h000, 4'd8);
    iv_b = 1'b1; cyc(); iv_b = 1'b0;
    vecs++; if ({mis_b, ill_b, be_b} !== {2'b10, 8'h00}) begin
      errs++; $display("FAIL ld64_mis: got %b %b %h want 1 0 00", mis_b, ill_b, be_b);
    end
    vecs++; if (cnt_b !== 16'd1) begin errs++; $display("FAIL ld64_cnt: got %0d want 1", cnt_b); end
    or_b = 1'b1; cyc(); or_b = 1'b0;
  endtask

  task automatic test_misaligned();
    vecs++; if (cnt_a !== 16'd0) begin errs++; $display("FAIL mis_cnt_pre: got %0d want 0", cnt_a); end
    drive_a(OP_LOAD, 3'b001, 32'h1001, 12'h000, 4'd3);
    iv_a = 1'b1; cyc(); iv_a = 1'b0;
    vecs++; if (mis_a !== 1'b1) begin errs++; $display("FAIL lh_mis: got %b want 1", mis_a); end
    vecs++; if (be_a !== 4'b0000) begin errs++; $display("FAIL lh_be: got %b want 0000", be_a); end
    vecs++; if (ill_a !== 1'b0) begin errs++; $display("FAIL lh_illegal: got %b want 0", ill_a); end
    vecs++; if (cnt_a !== 16'd1) begin errs++; $display("FAIL lh_cnt: got %0d want 1", cnt_a); end
    or_a = 1'b1; cyc();
    iv_a = 1'b1;
    repeat (100) cyc();
    vecs++; if (cnt_a !== 16'd101) begin errs++; $display("FAIL mis_cnt_stream: got %0d want 101", cnt_a); end
    repeat (70000) cyc();
    vecs++; if (cnt_a !== 16'hFFFF) begin errs++; $display("FAIL mis_cnt_sat: got %h want ffff", cnt_a); end
    iv_a = 1'b0; cyc(); or_a = 1'b0; cyc();
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL mis_drain: got %b want 0", ov_a); end
  endtask

  task automatic test_back_to_back();
    drive_a(OP_LOAD, 3'b010, 32'h100, 12'h000, 4'd1);
    or_a = 1'b0; iv_a = 1'b1;
    #1;
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL b2b_ir0: got %b want 1", ir_a); end
    cyc();
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL b2b_ir1: got %b want 1", ir_a); end
    tag_a = 4'd2; cyc();
    vecs++; if (ir_a !== 1'b0) begin errs++; $display("FAIL b2b_full: got %b want 0", ir_a); end
    vecs++; if (otag_a !== 4'd1) begin errs++; $display("FAIL b2b_head1: got %0d want 1", otag_a); end
    tag_a = 4'd3; cyc();
    vecs++; if ({ir_a, ov_a, otag_a} !== {2'b01, 4'd1}) begin
      errs++; $display("FAIL b2b_hold: got %b %b %0d want 0 1 1", ir_a, ov_a, otag_a);
    end
    or_a = 1'b1; cyc();
    vecs++; if (otag_a !== 4'd2) begin errs++; $display("FAIL b2b_head2: got %0d want 2", otag_a); end
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL b2b_ir_after_pop: got %b want 1", ir_a); end
    or_a = 1'b0; cyc();
    vecs++; if (ir_a !== 1'b0) begin errs++; $display("FAIL b2b_third_in: got %b want 0", ir_a); end
    iv_a = 1'b0; or_a = 1'b1; cyc();
    vecs++; if ({ov_a, otag_a} !== {1'b1, 4'd3}) begin
      errs++; $display("FAIL b2b_head3: got %b %0d want 1 3", ov_a, otag_a);
    end
    cyc();
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL b2b_empty: got %b want 0", ov_a); end
    or_a = 1'b0;
  endtask

  task automatic test_flush();
    drive_a(OP_LOAD, 3'b010, 32'h200, 12'h000, 4'd5);
    iv_a = 1'b1; cyc();
    tag_a = 4'd6; cyc();
    flush_a = 1'b1; tag_a = 4'd7;
    #1;
    vecs++; if (ir_a !== 1'b0) begin errs++; $display("FAIL flush_ir: got %b want 0", ir_a); end
    cyc();
    flush_a = 1'b0; iv_a = 1'b0;
    #1;
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL flush_ov: got %b want 0", ov_a); end
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL flush_ir_after: got %b want 1", ir_a); end
    vecs++; if (cnt_a !== 16'hFFFF) begin errs++; $display("FAIL flush_cnt: got %h want ffff", cnt_a); end
    cyc();
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL flush_dropped: got %b want 0", ov_a); end
  endtask

  task automatic test_rst_mid();
    drive_a(OP_LOAD, 3'b010, 32'h300, 12'h000, 4'd8);
    iv_a = 1'b1; cyc();
    tag_a = 4'd9; cyc();
    rst = 1'b1; tag_a = 4'd10; or_a = 1'b1; cyc();
    rst = 1'b0; iv_a = 1'b0; or_a = 1'b0;
    #1;
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL rst_mid_ov: got %b want 0", ov_a); end
    vecs++; if (cnt_a !== 16'd0) begin errs++; $display("FAIL rst_mid_cnt: got %h want 0", cnt_a); end
    vecs++; if ({addr_a, otag_a} !== 36'd0) begin errs++; $display("FAIL rst_mid_out: got %h want 0", {addr_a, otag_a}); end
    vecs++; if (ir_a !== 1'b1) begin errs++; $display("FAIL rst_mid_ir: got %b want 1", ir_a); end
    cyc();
    vecs++; if (ov_a !== 1'b0) begin errs++; $display("FAIL rst_mid_dropped: got %b want 0", ov_a); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_wrap();
    test_ld32();
    test_rv64();
    test_misaligned();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
